umi_arbiter: RTL and testbench
==============================

// Module: umi_arbiter
// PURPOSE
//  N-to-1 arbiter that shares one UMI packet channel between N requesters.
//  Packets are classed by the write bit (packet[0]):
//   - 1 = write/response class (high priority)
//   - 0 = read/request class (low priority)
//  Round-robin within each class; an aging counter stops low-class starvation.
//  Output is registered, sits upstream of umi_unpack, and gives full throughput.
// PARAMETERS
//  N      4    number of requesters (>=1)
//  UW     256  packet width
//  STARVE 15   consecutive high-class grants allowed while low class waits (>=1)
// PORTS
//  clk         in   1     clock
//  nreset      in   1     async active-low reset
//  in_valid    in   N     per-requester packet valid
//  in_packet   in   N*UW  requester i uses bits [i*UW +: UW]
//  in_ready    out  N     per-requester accept (combinational)
//  out_valid   out  1     output packet valid
//  out_packet  out  UW    granted packet
//  out_ready   in   1     downstream accept
//  out_grant   out  N     one-hot source index of out_packet
// BEHAVIOUR
//  Interface: one clock (clk); reset nreset is asynchronous, active-low.
//  Reset values:
//   - out_valid=0, out_packet=0, out_grant=0
//   - hi_ptr=0, lo_ptr=0, starve_cnt=0
//   - in_ready=0 while nreset is low
//  Handshake: a transfer occurs on a cycle with valid&ready.
//   - Requesters hold valid and packet stable until ready.
//   - The arbiter makes no commitment to a valid requester that has not yet
//     seen ready; a later high-class arrival may overtake it.
//  load = ~out_valid | out_ready. in_ready = grant & {N{load}}.
//  Class vectors:
//   - hi_req[i] = in_valid[i] &  pkt_i[0]
//   - lo_req[i] = in_valid[i] & ~pkt_i[0]
//  Class select:
//   - lo wins if lo_req!=0 and (hi_req==0 or starve_cnt==STARVE)
//   - otherwise hi wins if hi_req!=0
//   - otherwise no grant
//  Round-robin: the winning class searches from its pointer upward, wrapping
//  N-1 -> 0; the first set bit is the grant (one-hot, at most one bit).
//  On accept (load & grant!=0):
//   - out_packet <= pkt_g, out_valid <= 1, out_grant <= grant
//   - winning class pointer <= (g+1) mod N; the other pointer is unchanged
//  If load and no grant, out_valid <= 0 (out_packet/out_grant hold).
//  If no load (out_valid & ~out_ready): all registers hold and no in_ready.
//  starve_cnt, updated only on accept:
//   - hi grant with lo_req!=0: increment, saturating at STARVE
//   - lo grant: clear to 0
//   - lo_req==0 on any cycle: clear to 0
//  Latency: 1 cycle from input accept to out_valid.
//  Throughput: 1 packet/cycle with out_ready held high.
//  Edge cases:
//   - N=1: degenerates to a registered slice; pointers are constant 0.
//   - Reset mid-transfer: the packet in the output register is dropped;
//     out_valid falls asynchronously.
//   - Pop and fill in the same cycle: new packet loads, out_valid stays 1.
// TESTING
//  1 Reset: assert nreset=0 with all in_valid=1 -> in_ready=0, out_valid=0,
//    out_grant=0.
//  2 RR hi: inputs 0..3 all hi, out_ready=1 -> out_grant sequence
//    1,2,4,8,1,..., one per cycle, pkt order 0,1,2,3.
//  3 Priority: in0 lo, in2 hi at once -> in2 granted first; in0 on the next
//    load.
//  4 Starvation (STARVE=15): in0 lo held; in1,in2 hi continuously -> 15 hi
//    grants, then in0 granted; starve_cnt back to 0.
//  5 Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_packet,
//    out_grant stable; in_ready=0; no pointer change; resume -> same RR order.
//  6 Async reset at cycle 3 of case 2 -> out_valid=0 immediately; after
//    release, first grant is input 0.

Source files
------------

// File: rtl/umi_arbiter_if.sv
// Bundle of request-side and output-side handshake signals for umi_arbiter.
// The arbiter uses the slave modport; requesters/consumers drive the master side.
interface umi_arbiter_if #(
  parameter int N  = 4,
  parameter int UW = 256
);
  logic [N-1:0]    in_valid;
  logic [N*UW-1:0] in_packet;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [UW-1:0]   out_packet;
  logic            out_ready;
  logic [N-1:0]    out_grant;

  modport master (
    output in_valid, in_packet, out_ready,
    input  in_ready, out_valid, out_packet, out_grant
  );

  modport slave (
    input  in_valid, in_packet, out_ready,
    output in_ready, out_valid, out_packet, out_grant
  );
endinterface

// File: rtl/umi_arbiter.sv
// N-to-1 UMI packet arbiter: write class beats read class, round-robin inside
// each class, with an aging counter that lets a waiting read through after STARVE writes.
module umi_arbiter #(
  parameter int N      = 4,
  parameter int UW     = 256,
  parameter int STARVE = 15
) (
  input  logic           clk,
  input  logic           nreset,
  umi_arbiter_if.slave   bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(STARVE + 1);

  logic [UW-1:0] pkt [N];
  logic [N-1:0]  hi_req;
  logic [N-1:0]  lo_req;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_req
      assign pkt[gi]    = bus.in_packet[gi*UW +: UW];
      assign hi_req[gi] = bus.in_valid[gi] &  pkt[gi][0];
      assign lo_req[gi] = bus.in_valid[gi] & ~pkt[gi][0];
    end
  endgenerate

  logic          out_valid_q,  out_valid_d;
  logic [UW-1:0] out_packet_q, out_packet_d;
  logic [N-1:0]  out_grant_q,  out_grant_d;
  logic [PW-1:0] hi_ptr_q,     hi_ptr_d;
  logic [PW-1:0] lo_ptr_q,     lo_ptr_d;
  logic [CW-1:0] starve_q,     starve_d;

  logic          lo_any, hi_any, starved, sel_lo, sel_hi;
  logic          load, found, accept;
  logic [N-1:0]  req, grant;
  logic [PW-1:0] ptr, nxt_ptr;
  logic [UW-1:0] pkt_sel;
  int            idx;
  int            nidx;

  assign lo_any  = |lo_req;
  assign hi_any  = |hi_req;
  assign starved = (starve_q == CW'(STARVE));
  assign sel_lo  = lo_any & (~hi_any | starved);
  assign sel_hi  = ~sel_lo & hi_any;
  assign load    = ~out_valid_q | bus.out_ready;
  assign accept  = load & found;

  // Rotating first-set search starting at the winning class pointer.
  always_comb begin
    req     = sel_lo ? lo_req : (sel_hi ? hi_req : '0);
    ptr     = sel_lo ? lo_ptr_q : hi_ptr_q;
    grant   = '0;
    found   = 1'b0;
    nxt_ptr = '0;
    idx     = 0;
    nidx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        nidx       = idx + 1;
        if (nidx >= N) nidx = 0;
        nxt_ptr    = PW'(nidx);
      end
    end
  end

  always_comb begin
    pkt_sel = '0;
    for (int k = 0; k < N; k++) begin
      if (grant[k]) pkt_sel = pkt[k];
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_packet_d = out_packet_q;
    out_grant_d  = out_grant_q;
    hi_ptr_d     = hi_ptr_q;
    lo_ptr_d     = lo_ptr_q;
    starve_d     = starve_q;
    if (load) begin
      if (found) begin
        out_valid_d  = 1'b1;
        out_packet_d = pkt_sel;
        out_grant_d  = grant;
        if (sel_lo) lo_ptr_d = nxt_ptr;
        else        hi_ptr_d = nxt_ptr;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    // Aging only counts while a read is actually waiting.
    if (!lo_any) begin
      starve_d = '0;
    end else if (accept) begin
      if (sel_lo)        starve_d = '0;
      else if (!starved) starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid_q  <= 1'b0;
      out_packet_q <= '0;
      out_grant_q  <= '0;
      hi_ptr_q     <= '0;
      lo_ptr_q     <= '0;
      starve_q     <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_packet_q <= out_packet_d;
      out_grant_q  <= out_grant_d;
      hi_ptr_q     <= hi_ptr_d;
      lo_ptr_q     <= lo_ptr_d;
      starve_q     <= starve_d;
    end
  end

  assign bus.in_ready   = grant & {N{load & nreset}};
  assign bus.out_valid  = out_valid_q;
  assign bus.out_packet = out_packet_q;
  assign bus.out_grant  = out_grant_q;
endmodule

// File: tb/tb_umi_arbiter.sv
// Directed bench for umi_arbiter: reset, round-robin, class priority, aging,
// backpressure and asynchronous reset mid-stream.
module tb_umi_arbiter;
  localparam int N  = 4;
  localparam int UW = 32;

  logic clk;
  logic nreset;
  int   total = 0;
  int   bad   = 0;

  umi_arbiter_if #(.N(N), .UW(UW)) bus ();

  umi_arbiter #(.N(N), .UW(UW), .STARVE(15)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  logic [UW-1:0] pkt_a [N];
  assign bus.in_packet = {pkt_a[3], pkt_a[2], pkt_a[1], pkt_a[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [UW-1:0] mk(input int src, input logic w);
    mk = {8'(src), (w ? 8'h11 : 8'h22), 15'd0, w};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nreset        = 1'b0;
    bus.in_valid  = 4'hF;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) pkt_a[i] = mk(i, 1'b1);
    #1;
    // 1: reset state
    chk("rst_in_ready",  64'(bus.in_ready),  64'h0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_out_grant", 64'(bus.out_grant), 64'h0);
    $display("reset: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
    tick();
    tick();
    nreset = 1'b1;
    #1;

    // 2: round-robin within the write class, full throughput
    for (int k = 0; k < 8; k++) begin
      chk("rr_in_ready", 64'(bus.in_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk("rr_grant", 64'(bus.out_grant), 64'(4'b0001 << (k % 4)));
      chk("rr_pkt",   64'(bus.out_packet), 64'(mk(k % 4, 1'b1)));
      chk("rr_valid", 64'(bus.out_valid), 64'h1);
      $display("rr %0d: grant=%b pkt=%h", k, bus.out_grant, bus.out_packet);
    end
    bus.in_valid = 4'h0;
    tick();
    chk("idle_valid", 64'(bus.out_valid), 64'h0);

    // 3: write class overtakes read class
    pkt_a[0] = mk(0, 1'b0);
    pkt_a[2] = mk(2, 1'b1);
    bus.in_valid = 4'b0101;
    #1;
    chk("prio_in_ready", 64'(bus.in_ready), 64'h4);
    tick();
    chk("prio_grant_hi", 64'(bus.out_grant), 64'h4);
    chk("prio_pkt_hi",   64'(bus.out_packet), 64'(mk(2, 1'b1)));
    bus.in_valid = 4'b0001;
    #1;
    chk("prio_in_ready_lo", 64'(bus.in_ready), 64'h1);
    tick();
    chk("prio_grant_lo", 64'(bus.out_grant), 64'h1);
    chk("prio_pkt_lo",   64'(bus.out_packet), 64'(mk(0, 1'b0)));
    $display("prio: hi then lo grant=%b", bus.out_grant);
    bus.in_valid = 4'h0;
    tick();

    // 4: aging lets the read through after 15 writes (hi_ptr=3, lo_ptr=1)
    pkt_a[1] = mk(1, 1'b1);
    bus.in_valid = 4'b0111;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("starve_hi_grant", 64'(bus.out_grant), ((k % 2) == 0) ? 64'h2 : 64'h4);
    end
    tick();
    chk("starve_lo_grant", 64'(bus.out_grant), 64'h1);
    chk("starve_lo_pkt",   64'(bus.out_packet), 64'(mk(0, 1'b0)));
    tick();
    chk("starve_cleared", 64'(bus.out_grant), 64'h4);
    $display("starve: lo served after 15 hi, next grant=%b", bus.out_grant);
    bus.in_valid = 4'h0;
    tick();

    // 5: backpressure (hi_ptr=3)
    for (int i = 0; i < N; i++) pkt_a[i] = mk(i, 1'b1);
    bus.in_valid = 4'hF;
    tick();
    chk("bp_first_grant", 64'(bus.out_grant), 64'h8);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_in_ready", 64'(bus.in_ready), 64'h0);
      tick();
      chk("bp_grant", 64'(bus.out_grant), 64'h8);
      chk("bp_pkt",   64'(bus.out_packet), 64'(mk(3, 1'b1)));
      chk("bp_valid", 64'(bus.out_valid), 64'h1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 64'(bus.in_ready), 64'h1);
    tick();
    chk("bp_resume_g0", 64'(bus.out_grant), 64'h1);
    tick();
    chk("bp_resume_g1", 64'(bus.out_grant), 64'h2);
    $display("bp: held 5 cycles, resumed grant=%b", bus.out_grant);

    // 6: asynchronous reset mid-stream
    tick();
    tick();
    tick();
    #2;
    nreset = 1'b0;
    #1;
    chk("areset_valid", 64'(bus.out_valid), 64'h0);
    chk("areset_grant", 64'(bus.out_grant), 64'h0);
    chk("areset_ready", 64'(bus.in_ready),  64'h0);
    tick();
    nreset = 1'b1;
    #1;
    chk("areset_rel_ready", 64'(bus.in_ready), 64'h1);
    tick();
    chk("areset_rel_grant", 64'(bus.out_grant), 64'h1);
    chk("areset_rel_pkt",   64'(bus.out_packet), 64'(mk(0, 1'b1)));
    $display("areset: first grant after release=%b", bus.out_grant);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
